// File: rtl/morse_pkg.sv
// Shared state encoding and morse timing constants for the morse front-end.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP,
        LOOKUP,
        EMIT,
        WORD
    } state_t;

    localparam logic [2:0] DASH_UNITS       = 3'd2;
    localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;
    localparam logic [2:0] MAX_SYMBOLS      = 3'd5;
    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] ASCII_NONE       = 8'h00;

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit timer: counts clock cycles into whole units, saturating at the
// word-gap length; cleared whenever the key line changes.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int CLK_PER_UNIT = 1000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    output logic [2:0] unit_cnt,
    output logic       unit_tick
);

    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CLK_PER_UNIT - 1);

    logic [CNT_W-1:0] cyc_cnt;

    // unit_tick marks the cycle whose clock edge completes a unit
    assign unit_tick = (cyc_cnt == CYC_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cyc_cnt  <= '0;
            unit_cnt <= '0;
        end else if (unit_tick) begin
            cyc_cnt <= '0;
            if (unit_cnt != WORD_GAP_UNITS) begin
                unit_cnt <= unit_cnt + 3'd1;
            end
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Morse front-end sequencer: classifies key marks, builds the code for the
// external decoder and delivers ASCII over valid/ready.
// Optional word-space output is enabled by defining MORSE_SEQ_WORD_SPACE_EN.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int CLK_PER_UNIT = 1000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic [4:0] morse_code,
    output logic [2:0] morse_len,
    input  logic [7:0] ascii_in,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       err_pulse
);

    state_t     state;
    logic       key_q;
    logic       overflow;
    logic       rise_pend;
    logic [2:0] unit_cnt;
    logic       unit_tick;

    logic rise;
    logic fall;
    logic letter_done;
    logic word_done;
    logic can_load;

    // Edges are taken on the edge at which key_q itself changes
    assign rise        = key_in & ~key_q;
    assign fall        = ~key_in & key_q;
    assign letter_done = unit_tick && (unit_cnt == LETTER_GAP_UNITS - 3'd1);
    assign word_done   = unit_tick && (unit_cnt == WORD_GAP_UNITS - 3'd1);
    assign can_load    = ~char_valid | char_ready;

    morse_unit_timer #(
        .CLK_PER_UNIT (CLK_PER_UNIT),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (rise | fall),
        .unit_cnt  (unit_cnt),
        .unit_tick (unit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_q      <= 1'b0;
            overflow   <= 1'b0;
            rise_pend  <= 1'b0;
            morse_code <= '0;
            morse_len  <= '0;
            char_data  <= '0;
            char_valid <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            key_q     <= key_in;
            err_pulse <= 1'b0;
            if (char_valid && char_ready) begin
                char_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise) state <= MARK;
                end
                MARK: begin
                    if (fall) begin
                        if (morse_len == MAX_SYMBOLS) begin
                            overflow <= 1'b1;
                        end else begin
                            morse_code[3'd4 - morse_len] <= (unit_cnt >= DASH_UNITS);
                            morse_len <= morse_len + 3'd1;
                        end
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (rise) state <= MARK;
                    else if (letter_done) state <= LOOKUP;
                end
                LOOKUP: begin
                    if (rise) rise_pend <= 1'b1;
                    state <= EMIT;
                end
                EMIT: begin
                    if (overflow || ascii_in == ASCII_NONE) begin
                        err_pulse <= 1'b1;
                    end else if (!can_load) begin
                        err_pulse <= 1'b1;
                    end else begin
                        char_data  <= ascii_in;
                        char_valid <= 1'b1;
                    end
                    morse_code <= '0;
                    morse_len  <= '0;
                    overflow   <= 1'b0;
                    rise_pend  <= 1'b0;
                    state      <= (rise || rise_pend) ? MARK : WORD;
                end
                WORD: begin
                    if (rise) begin
                        state <= MARK;
                    end else if (word_done) begin
`ifdef MORSE_SEQ_WORD_SPACE_EN
                        if (!can_load) begin
                            err_pulse <= 1'b1;
                        end else begin
                            char_data  <= ASCII_SPACE;
                            char_valid <= 1'b1;
                        end
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer with a string-table morse decoder
// standing in for the combinational decoder at the parent level.
module tb_morse_sequencer;

    localparam int CPU = 4;
`ifdef MORSE_SEQ_WORD_SPACE_EN
    localparam bit SPACE_EN = 1'b1;
`else
    localparam bit SPACE_EN = 1'b0;
`endif

    typedef struct {
        string      pat;
        logic [4:0] code;
        logic [2:0] len;
        logic [7:0] ch;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_in = 1'b0;
    logic       char_ready = 1'b0;
    logic [7:0] ascii_in;
    logic [4:0] morse_code;
    logic [2:0] morse_len;
    logic [7:0] char_data;
    logic       char_valid;
    logic       err_pulse;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    string morse_tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."
    };

    always #5 clk = ~clk;

    morse_sequencer #(
        .CLK_PER_UNIT (CPU),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .morse_code (morse_code),
        .morse_len  (morse_len),
        .ascii_in   (ascii_in),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .err_pulse  (err_pulse)
    );

    function automatic logic [7:0] char_of(int i);
        return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
    endfunction

    function automatic logic [4:0] pat_code(string p);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < p.len() && i < 5; i++) c[4-i] = (p[i] == "-");
        return c;
    endfunction

    function automatic logic [7:0] decode(logic [4:0] code, logic [2:0] len);
        for (int i = 0; i < 36; i++)
            if (len != 0 && morse_tab[i].len() == int'(len) && pat_code(morse_tab[i]) == code)
                return char_of(i);
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_char(string p);
        for (int i = 0; i < 36; i++)
            if (morse_tab[i] == p) return char_of(i);
        return 8'h00;
    endfunction

    always_comb ascii_in = decode(morse_code, morse_len);

    // Collect every accepted character and every error pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (char_valid && char_ready) rx_q.push_back(char_data);
            if (err_pulse) err_seen++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Dot = 1 unit, dash = 3 units, 1-unit gaps; random timing stays clear of class boundaries
    task automatic applyStimulus(string p, bit rnd);
        for (int i = 0; i < p.len(); i++) begin
            int mark;
            if (p[i] == "-") mark = rnd ? int'($urandom_range(3*CPU, 8*CPU)) : 3*CPU;
            else             mark = rnd ? int'($urandom_range(2, CPU+1)) : CPU;
            key_in = 1'b1;
            tick(mark);
            key_in = 1'b0;
            if (i < p.len() - 1) tick(rnd ? int'($urandom_range(1, 2*CPU)) : CPU);
        end
    endtask

    task automatic compare_rx(string tag, int exp_err, int err0);
        int n;
        checkOutput({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_char%0d", tag, i), rx_q[i], exp_q[i]);
        checkOutput({tag, "_errs"}, err_seen - err0, exp_err);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t       vecs[7];
        int         n;
        int         err0;
        int         exp_err;
        string      p;
        logic [7:0] c;
        bit         word;

        vecs[0] = '{".",      5'b00000, 3'd1, 8'h45};
        vecs[1] = '{".-..",   5'b01000, 3'd4, 8'h4C};
        vecs[2] = '{"--.-",   5'b11010, 3'd4, 8'h51};
        vecs[3] = '{"......", 5'b00000, 3'd5, 8'h00};
        vecs[4] = '{"..--",   5'b00110, 3'd4, 8'h00};
        vecs[5] = '{".----",  5'b01111, 3'd5, 8'h31};
        vecs[6] = '{"-",      5'b10000, 3'd1, 8'h54};

        rst = 1'b1;
        tick(3);
        checkOutput("rst_code",  morse_code, 0);
        checkOutput("rst_len",   morse_len, 0);
        checkOutput("rst_data",  char_data, 0);
        checkOutput("rst_valid", char_valid, 0);
        checkOutput("rst_err",   err_pulse, 0);
        rst = 1'b0;
        tick(2);

        // 'E' with the sink stalled: valid appears 2 cycles after the 3-unit gap threshold
        $display("[TB] latency and handshake");
        char_ready = 1'b0;
        err0 = err_seen;
        applyStimulus(".", 1'b0);
        n = 0;
        while (n < 60 && !char_valid) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        checkOutput("latency", n, 3*CPU + 3);
        checkOutput("lat_data", char_data, 8'h45);
        char_ready = 1'b1;
        tick(1);
        checkOutput("lat_valid_drop", char_valid, 0);
        tick(10*CPU);
        exp_q.push_back(8'h45);
        if (SPACE_EN) exp_q.push_back(8'h20);
        compare_rx("lat", 0, err0);

        $display("[TB] vector table");
        for (int v = 0; v < 7; v++) begin
            err0 = err_seen;
            applyStimulus(vecs[v].pat, 1'b0);
            tick(2);
            checkOutput($sformatf("vec%0d_code", v), morse_code, vecs[v].code);
            checkOutput($sformatf("vec%0d_len", v), morse_len, vecs[v].len);
            tick(10*CPU);
            checkOutput($sformatf("vec%0d_len_clr", v), morse_len, 0);
            if (vecs[v].ch != 8'h00) exp_q.push_back(vecs[v].ch);
            if (SPACE_EN) exp_q.push_back(8'h20);
            compare_rx($sformatf("vec%0d", v), (vecs[v].ch == 8'h00) ? 1 : 0, err0);
        end

        $display("[TB] T then E with stalled sink");
        char_ready = 1'b0;
        err0 = err_seen;
        applyStimulus("-", 1'b0);
        tick(4*CPU);
        applyStimulus(".", 1'b0);
        tick(4*CPU);
        checkOutput("drop_valid", char_valid, 1);
        checkOutput("drop_data", char_data, 8'h54);
        checkOutput("drop_err", err_seen - err0, 1);
        char_ready = 1'b1;
        tick(1);
        checkOutput("drop_release", char_valid, 0);
        tick(10*CPU);
        exp_q.push_back(8'h54);
        if (SPACE_EN) exp_q.push_back(8'h20);
        compare_rx("drop", 1, err0);

        // Next mark begins while the previous letter is in LOOKUP, then in EMIT
        $display("[TB] key edge during lookup/emit");
        err0 = err_seen;
        applyStimulus(".", 1'b0);
        tick(3*CPU + 1);
        applyStimulus(".", 1'b0);
        tick(3*CPU + 2);
        applyStimulus(".", 1'b0);
        tick(10*CPU);
        repeat (3) exp_q.push_back(8'h45);
        if (SPACE_EN) exp_q.push_back(8'h20);
        compare_rx("edge", 0, err0);

        $display("[TB] reset mid-letter");
        char_ready = 1'b0;
        applyStimulus("-", 1'b0);
        tick(4*CPU);
        key_in = 1'b1;
        tick(3*CPU);
        key_in = 1'b0;
        tick(CPU);
        key_in = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        key_in = 1'b0;
        checkOutput("mid_rst_code",  morse_code, 0);
        checkOutput("mid_rst_len",   morse_len, 0);
        checkOutput("mid_rst_data",  char_data, 0);
        checkOutput("mid_rst_valid", char_valid, 0);
        checkOutput("mid_rst_err",   err_pulse, 0);
        tick(1);
        rst = 1'b0;
        char_ready = 1'b1;
        tick(2);
        rx_q.delete();
        err0 = err_seen;
        applyStimulus(".", 1'b0);
        tick(10*CPU);
        exp_q.push_back(8'h45);
        if (SPACE_EN) exp_q.push_back(8'h20);
        compare_rx("post_rst", 0, err0);

        $display("[TB] random letters");
        char_ready = 1'b1;
        err0 = err_seen;
        exp_err = 0;
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                p = morse_tab[$urandom_range(0, 35)];
            end else begin
                p = "";
                n = int'($urandom_range(1, 6));
                for (int j = 0; j < n; j++) begin
                    if ($urandom_range(0, 1) == 1) p = {p, "-"};
                    else p = {p, "."};
                end
            end
            applyStimulus(p, 1'b1);
            c = (p.len() > 5) ? 8'h00 : ref_char(p);
            if (c != 8'h00) exp_q.push_back(c);
            else exp_err++;
            word = (i == 24) || ($urandom_range(0, 3) == 0);
            if (word) begin
                if (SPACE_EN) exp_q.push_back(8'h20);
                tick(int'($urandom_range(8*CPU, 10*CPU)));
            end else begin
                tick(int'($urandom_range(3*CPU + 1, 6*CPU)));
            end
        end
        tick(2);
        compare_rx("rand", exp_err, err0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
